// File: rtl/multu_seq.sv
// Iterative shift-add unsigned multiplier feeding the HI/LO register pair; one product per WIDTH cycles.
// Optional zero-operand shortcut enabled by defining MULTU_EARLY_TERM_EN.
module multu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   p_step;

  // Upper half is W+1 bits wide so the carry out of the add survives the shift.
  always_comb begin
    sum    = p_q[2*WIDTH:WIDTH] + (p_q[0] ? {1'b0, m_q} : '0);
    p_step = {sum, p_q[WIDTH-1:0]} >> 1;
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          p_d     = {{(WIDTH+1){1'b0}}, b};
          m_d     = a;
          cnt_d   = '0;
          state_d = RUN;
`ifdef MULTU_EARLY_TERM_EN
          if ((a == '0) || (b == '0)) begin
            state_d = DONE;
            hi_d    = '0;
            lo_d    = '0;
          end
`endif
        end
      end
      RUN: begin
        p_d   = p_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d      = DONE;
          {hi_d, lo_d} = p_step[2*WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      p_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign hilo_we = done;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_multu_seq.sv
// Self-checking bench for multu_seq: random and directed operands checked against a 64-bit product model.
module tb_multu_seq;
  localparam int W = 32;
`ifdef MULTU_EARLY_TERM_EN
  localparam int ZERO_N    = 0;
  localparam int ZERO_BUSY = 0;
`else
  localparam int ZERO_N    = W;
  localparam int ZERO_BUSY = W;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, hilo_we;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  multu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .hilo_we(hilo_we), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    return {{W{1'b0}}, x} * {{W{1'b0}}, y};
  endfunction

  function automatic logic [W-1:0] rand_nz();
    logic [W-1:0] v;
    v = $urandom;
    if (v == '0) v = 1;
    return v;
  endfunction

  // Called 1 time unit after an edge; returns at 1 time unit after the accepting edge.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
    a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges until done is seen (bounded) and cycles with busy high.
  task automatic wait_done(output int n, output int bc);
    n = 0; bc = 0;
    while (done !== 1'b1 && n < 200) begin
      if (busy === 1'b1) bc++;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({busy, done, hilo_we} !== 3'b000 || hi !== '0 || lo !== '0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b we=%b hi=%h lo=%h required all 0", busy, done, hilo_we, hi, lo);
    end
    reset = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [4];
    logic [W-1:0] tb [4];
    logic [2*W-1:0] exp_p;
    int n, bc;
    ta[0] = 32'd3;        tb[0] = 32'd5;
    ta[1] = 32'hFFFFFFFF; tb[1] = 32'hFFFFFFFF;
    ta[2] = 32'h00000001; tb[2] = 32'hFFFFFFFF;
    ta[3] = 32'h80000000; tb[3] = 32'h00000002;
    for (int i = 0; i < 4; i++) begin
      exp_p = ref_mul(ta[i], tb[i]);
      start_op(ta[i], tb[i]);
      wait_done(n, bc);
      checks++;
      if (n !== W || bc !== W) begin
        errors++;
        $display("FAIL directed_latency[%0d] edges=%0d busy=%0d required %0d %0d", i, n, bc, W, W);
      end
      checks++;
      if ({hi, lo} !== exp_p || hilo_we !== 1'b1) begin
        errors++;
        $display("FAIL directed_result[%0d] hi=%h lo=%h we=%b required %h we=1", i, hi, lo, hilo_we, exp_p);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || hilo_we !== 1'b0 || {hi, lo} !== exp_p) begin
        errors++;
        $display("FAIL directed_pulse_hold[%0d] done=%b we=%b hi=%h lo=%h required 0 0 %h", i, done, hilo_we, hi, lo, exp_p);
      end
      $display("op a=%h b=%h -> hi=%h lo=%h", ta[i], tb[i], hi, lo);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] x, y;
    logic [2*W-1:0] exp_p;
    int n, bc;
    for (int i = 0; i < 8; i++) begin
      x = rand_nz(); y = rand_nz();
      if (i == 0) x = 32'hFFFFFFFF;
      exp_p = ref_mul(x, y);
      start_op(x, y);
      a = $urandom; b = $urandom;
      wait_done(n, bc);
      checks++;
      if (n !== W || {hi, lo} !== exp_p || hilo_we !== 1'b1) begin
        errors++;
        $display("FAIL random[%0d] edges=%0d hi=%h lo=%h required edges=%0d %h", i, n, hi, lo, W, exp_p);
      end
      $display("op a=%h b=%h -> hi=%h lo=%h", x, y, hi, lo);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_start_held();
    logic [W-1:0] x, y;
    logic [2*W-1:0] exp_p;
    int n, bc;
    x = rand_nz(); y = rand_nz();
    exp_p = ref_mul(x, y);
    a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    repeat (10) begin @(posedge clk); #1; end
    a = 32'd7; b = 32'd7;
    wait_done(n, bc);
    checks++;
    if (n !== W - 10 || {hi, lo} !== exp_p) begin
      errors++;
      $display("FAIL start_held edges=%0d hi=%h lo=%h required edges=%0d %h", n, hi, lo, W - 10, exp_p);
    end
    $display("op a=%h b=%h (start held) -> hi=%h lo=%h", x, y, hi, lo);
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL held_reaccept busy=%b done=%b required 1 0", busy, done);
    end
    wait_done(n, bc);
    checks++;
    if (n !== W || {hi, lo} !== ref_mul(32'd7, 32'd7)) begin
      errors++;
      $display("FAIL held_second edges=%0d hi=%h lo=%h required edges=%0d %h", n, hi, lo, W, ref_mul(32'd7, 32'd7));
    end
    $display("op a=7 b=7 -> hi=%h lo=%h", hi, lo);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int n, bc;
    start_op(32'h00010000, 32'h00010000);
    wait_done(n, bc);
    checks++;
    if (n !== W || hi !== 32'd1 || lo !== 32'd0) begin
      errors++;
      $display("FAIL b2b_first edges=%0d hi=%h lo=%h required edges=%0d 1 0", n, hi, lo, W);
    end
    a = 32'd2; b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || hi !== 32'd1 || lo !== 32'd0) begin
      errors++;
      $display("FAIL b2b_accept done=%b busy=%b hi=%h lo=%h required 0 1 1 0", done, busy, hi, lo);
    end
    wait_done(n, bc);
    checks++;
    if (n !== W || bc !== W || hi !== 32'd0 || lo !== 32'h12) begin
      errors++;
      $display("FAIL b2b_second edges=%0d busy=%0d hi=%h lo=%h required %0d %0d 0 12", n, bc, hi, lo, W, W);
    end
    $display("op back-to-back a=2 b=9 -> hi=%h lo=%h", hi, lo);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int bad;
    start_op(rand_nz(), rand_nz());
    repeat (12) begin @(posedge clk); #1; end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midrun_busy busy=%b required 1", busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, hilo_we} !== 3'b000 || hi !== '0 || lo !== '0) begin
      errors++;
      $display("FAIL async_reset busy=%b done=%b we=%b hi=%h lo=%h required all 0", busy, done, hilo_we, hi, lo);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || hilo_we !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL post_reset_idle bad_cycles=%0d required 0", bad);
    end
  endtask

  task automatic test_zero_operand();
    logic [W-1:0] za [2];
    logic [W-1:0] zb [2];
    int n, bc;
    za[0] = 32'd0;      zb[0] = 32'h1234;
    za[1] = 32'hABCD;   zb[1] = 32'd0;
    for (int i = 0; i < 2; i++) begin
      start_op(rand_nz(), rand_nz());
      wait_done(n, bc);
      @(posedge clk); #1;
      start_op(za[i], zb[i]);
      wait_done(n, bc);
      checks++;
      if (n !== ZERO_N || bc !== ZERO_BUSY || hi !== '0 || lo !== '0 || hilo_we !== 1'b1) begin
        errors++;
        $display("FAIL zero_op[%0d] edges=%0d busy=%0d hi=%h lo=%h we=%b required %0d %0d 0 0 1", i, n, bc, hi, lo, hilo_we, ZERO_N, ZERO_BUSY);
      end
      $display("op a=%h b=%h -> hi=%h lo=%h after %0d edges", za[i], zb[i], hi, lo, n);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_held();
    test_back_to_back();
    test_reset_mid_run();
    test_zero_operand();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
